// File: rtl/flit_serializer.sv
// flit_serializer: frames each popped flit as SYNC_BYTE, flit bytes MSB-first, then an XOR checksum byte.
package types;
    typedef struct packed {
        logic [7:0] src_id;
        logic [7:0] dst_id;
    } header_t;
    typedef struct packed {
        header_t     header;
        logic [31:0] payload;
    } flit_t;
endpackage

module flit_serializer
    import types::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'h7E,
    parameter int         NUM_BYTES = $bits(flit_t) / 8
) (
    input  logic       clk,
    input  logic       rst,
    input  flit_t      poped_flit,
    input  logic       poped_flit_valid,
    output logic       poped_flit_ready,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready,
    output logic       busy
);
    localparam int IW = $clog2(NUM_BYTES) + 1;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

    state_t        state, state_n;
    flit_t         flit_q, flit_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0]    csum, csum_n;
    logic [7:0]    tx_n;
    logic          txv_n;
    logic          xfer;

    // Shift-based select keeps every index bit in use whatever NUM_BYTES is.
    function automatic logic [7:0] byte_at(input flit_t f, input logic [IW-1:0] k);
        logic [8*NUM_BYTES-1:0] s;
        s = f >> {k, 3'b000};
        return s[7:0];
    endfunction

    assign poped_flit_ready = (state == IDLE) && !rst;
    assign busy             = (state != IDLE);
    assign xfer             = tx_byte_valid && tx_byte_ready;

    always_comb begin
        state_n = state;
        flit_n  = flit_q;
        idx_n   = idx;
        csum_n  = csum;
        tx_n    = tx_byte;
        txv_n   = tx_byte_valid;
        case (state)
            IDLE: if (poped_flit_valid && poped_flit_ready) begin
                state_n = SYNC;
                flit_n  = poped_flit;
                idx_n   = '0;
                csum_n  = 8'h00;
                tx_n    = SYNC_BYTE;
                txv_n   = 1'b1;
            end
            SYNC: if (xfer) begin
                state_n = DATA;
                idx_n   = IW'(NUM_BYTES - 1);
                tx_n    = byte_at(flit_q, IW'(NUM_BYTES - 1));
            end
            DATA: if (xfer) begin
                csum_n  = csum ^ tx_byte;
                state_n = (idx == '0) ? CSUM : DATA;
                idx_n   = (idx == '0) ? idx : idx - 1'b1;
                tx_n    = (idx == '0) ? (csum ^ tx_byte) : byte_at(flit_q, idx - 1'b1);
            end
            CSUM: if (xfer) begin
                state_n = IDLE;
                tx_n    = 8'h00;
                txv_n   = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            flit_q        <= '0;
            idx           <= '0;
            csum          <= 8'h00;
            tx_byte       <= 8'h00;
            tx_byte_valid <= 1'b0;
        end else begin
            state         <= state_n;
            flit_q        <= flit_n;
            idx           <= idx_n;
            csum          <= csum_n;
            tx_byte       <= tx_n;
            tx_byte_valid <= txv_n;
        end
    end
endmodule
